// File: rtl/scmp_bus_ctl.sv
// scmp_bus_ctl: SC/MP bus-cycle controller, turning ADS/RD/WR pin cycles into a single-outstanding req/ack memory transaction
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_cpu_addr[11:0]          core address A11..A0
//   i_cpu_D_o[7:0]            core data out ({H,D,I,R,A15..A12} during ADS, write data during WR)
//   i_cpu_ADS_n/RD_n/WR_n     active-low core strobes
//   o_cpu_D_i[7:0]            registered read data back to the core
//   o_cpu_hold                stall request to the core
//   o_mem_addr/flags/wdata/we latched transaction fields
//   o_mem_req, i_mem_ack      request/acknowledge handshake, i_mem_rdata read data
//   o_bus_err                 one-cycle pulse on timeout abort
//   o_halt_o, i_cont_i        halt level set by H-flagged ADS, cleared by cont
module scmp_bus_ctl #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_D_o,
    input  logic        i_cpu_ADS_n,
    input  logic        i_cpu_RD_n,
    input  logic        i_cpu_WR_n,
    output logic [7:0]  o_cpu_D_i,
    output logic        o_cpu_hold,
    output logic [15:0] o_mem_addr,
    output logic [3:0]  o_mem_flags,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_bus_err,
    output logic        o_halt_o,
    input  logic        i_cont_i
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    typedef enum logic [2:0] {IDLE, ADDR, RD_REQ, WR_REQ, DONE} state_t;
    state_t r_state, w_next;
    logic [15:0] r_addr;
    logic [3:0] r_flags;
    logic [7:0] r_wdata, r_din;
    logic [CW-1:0] r_cnt;
    logic r_err, r_halt;
    logic w_latch, w_req, w_tout, w_end;
    assign w_latch = (r_state == IDLE || r_state == ADDR) && !i_cpu_ADS_n;
    assign w_req = r_state == RD_REQ || r_state == WR_REQ;
    // ack in the timeout cycle takes precedence over the abort
    assign w_tout = (TIMEOUT != 0) && r_cnt == LAST && !i_mem_ack;
    assign w_end = w_req && (i_mem_ack || w_tout);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = !i_cpu_ADS_n ? ADDR : IDLE;
            ADDR: w_next = !i_cpu_ADS_n ? ADDR : !i_cpu_RD_n ? RD_REQ : !i_cpu_WR_n ? WR_REQ : ADDR;
            RD_REQ, WR_REQ: w_next = w_end ? DONE : r_state;
            DONE: w_next = (i_cpu_RD_n && i_cpu_WR_n) ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_flags <= '0;
            r_wdata <= '0;
            r_din   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_req && w_tout;
            // counter sits at zero outside the request states, so it is clear on entry
            r_cnt   <= w_req ? r_cnt + 1'b1 : '0;
            if (w_latch) begin
                r_addr  <= {i_cpu_D_o[3:0], i_cpu_addr};
                r_flags <= i_cpu_D_o[7:4];
            end
            if (r_state == ADDR && w_next == WR_REQ)
                r_wdata <= i_cpu_D_o;
            if (r_state == RD_REQ && w_end)
                r_din <= i_mem_ack ? i_mem_rdata : 8'hFF;
            if (w_latch && i_cpu_D_o[7])
                r_halt <= 1'b1;
            else if (i_cont_i)
                r_halt <= 1'b0;
        end
    end
    assign o_cpu_D_i   = r_din;
    assign o_cpu_hold  = (r_state == ADDR && (!i_cpu_RD_n || !i_cpu_WR_n)) || w_req;
    assign o_mem_addr  = r_addr;
    assign o_mem_flags = r_flags;
    assign o_mem_wdata = r_wdata;
    assign o_mem_we    = r_state == WR_REQ;
    assign o_mem_req   = w_req;
    assign o_bus_err   = r_err;
    assign o_halt_o    = r_halt;
endmodule

// File: tb/tb_scmp_bus_ctl.sv
// tb_scmp_bus_ctl: directed scoreboard bench for scmp_bus_ctl
module tb_scmp_bus_ctl;
    localparam int TO = 16;
    logic clk = 1'b0, rst_n = 1'b0, ads_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, ack = 1'b0, cont = 1'b0;
    logic [11:0] addr = '0;
    logic [7:0] dout = '0, rdata = '0;
    logic [7:0] din, mwd;
    logic [15:0] maddr;
    logic [3:0] mflags;
    logic hold, mwe, req, err, halt;
    int n_cmp = 0, n_err = 0;
    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [7:0]  wd;
        logic [7:0]  din;
    } exp_t;
    exp_t q[$];
    logic [15:0] cur_a = '0;
    logic [7:0] last_din = '0, last_wd = '0;

    scmp_bus_ctl #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_addr(addr), .i_cpu_D_o(dout),
        .i_cpu_ADS_n(ads_n), .i_cpu_RD_n(rd_n), .i_cpu_WR_n(wr_n),
        .o_cpu_D_i(din), .o_cpu_hold(hold), .o_mem_addr(maddr), .o_mem_flags(mflags),
        .o_mem_wdata(mwd), .o_mem_we(mwe), .o_mem_req(req), .i_mem_ack(ack),
        .i_mem_rdata(rdata), .o_bus_err(err), .o_halt_o(halt), .i_cont_i(cont)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ads(input logic [11:0] a, input logic [7:0] d, input logic c);
        @(posedge clk); #1;
        ads_n = 1'b0; addr = a; dout = d; cont = c;
        cur_a = {d[3:0], a};
        @(posedge clk); #1;
        ads_n = 1'b1; cont = 1'b0;
    endtask

    // ack_at: request cycle (1-based) in which ack is driven; 0 = never
    task automatic run(input string tag, input logic rd, input int ack_at, input logic [7:0] rv, input logic [7:0] wv);
        int reqn = 0, holdn = 0, errn = 0, exp_req;
        bit done = 0;
        exp_t e;
        exp_req = (ack_at == 0 || ack_at > TO) ? TO : ack_at;
        @(posedge clk); #1;
        e.a = cur_a;
        e.we = !rd;
        e.wd = rd ? last_wd : wv;
        e.din = !rd ? last_din : (ack_at == 0 || ack_at > TO) ? 8'hFF : rv;
        q.push_back(e);
        if (rd) rd_n = 1'b0;
        else begin
            wr_n = 1'b0;
            dout = wv;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            holdn += int'(hold);
            errn += int'(err);
            if (req) begin
                reqn++;
                if (reqn == 1) begin
                    chk({tag, "_addr"}, maddr, q[0].a);
                    chk({tag, "_we"}, mwe, q[0].we);
                    chk({tag, "_wdata"}, mwd, q[0].wd);
                end
                ack = (reqn == ack_at);
                rdata = rv;
            end else if (reqn > 0) begin
                done = 1;
                ack = 1'b0;
                rd_n = 1'b1;
                wr_n = 1'b1;
            end
        end
        if (!done) chk({tag, "_bound"}, 0, 1);
        e = q.pop_front();
        chk({tag, "_din"}, din, e.din);
        @(negedge clk);
        errn += int'(err);
        chk({tag, "_req_cycles"}, reqn, exp_req);
        chk({tag, "_hold_cycles"}, holdn, exp_req + 1);
        chk({tag, "_err_cycles"}, errn, (ack_at == 0 || ack_at > TO) ? 1 : 0);
        last_din = e.din;
        last_wd = e.wd;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_all", {din, hold, maddr, mflags, mwd, mwe, req, err, halt}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // strobes without ADS are ignored
        rd_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("orphan_rd", {req, hold}, 0);
        rd_n = 1'b1; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("orphan_wr", {req, hold}, 0);
        wr_n = 1'b1;
        // zero-wait read
        ads(12'h345, 8'hA7, 1'b0);
        @(negedge clk);
        chk("zw_addr", maddr, 16'h7345);
        chk("zw_flags", mflags, 4'hA);
        chk("zw_halt", halt, 1);
        run("zw", 1'b1, 1, 8'h5C, 8'h00);
        // cont clears halt
        @(posedge clk); #1; cont = 1'b1;
        @(posedge clk); #1; cont = 1'b0;
        @(negedge clk);
        chk("cont_clear", halt, 0);
        // wait-state read
        ads(12'h123, 8'h05, 1'b0);
        run("ws", 1'b1, 4, 8'h99, 8'h00);
        chk("ws_halt", halt, 0);
        // write
        ads(12'h0FF, 8'h10, 1'b0);
        @(negedge clk);
        chk("wr_addr", maddr, 16'h00FF);
        chk("wr_flags", mflags, 4'h1);
        run("wr", 1'b0, 2, 8'hEE, 8'h3C);
        chk("wr_wdata_hold", mwd, 8'h3C);
        // timeout with no ack
        ads(12'h200, 8'h00, 1'b0);
        run("to", 1'b1, 0, 8'h00, 8'h00);
        // ack on the final cycle beats timeout
        ads(12'h201, 8'h00, 1'b0);
        run("to_ack", 1'b1, TO, 8'h42, 8'h00);
        // reset mid-transaction
        ads(12'hABC, 8'h02, 1'b0);
        @(posedge clk); #1; rd_n = 1'b0;
        @(negedge clk);
        chk("rst_pre_hold", hold, 1);
        @(negedge clk);
        chk("rst_pre_req", req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_all", {din, hold, maddr, mflags, mwd, mwe, req, err, halt}, 0);
        rst_n = 1'b1; ack = 1'b1; rdata = 8'hEE;
        @(negedge clk);
        chk("rst_late_ack", {din, hold, req, err}, 0);
        @(negedge clk);
        chk("rst_late_ack2", {din, hold, req}, 0);
        ack = 1'b0; rd_n = 1'b1;
        last_din = '0; last_wd = '0;
        ads(12'h456, 8'h0B, 1'b0);
        @(negedge clk);
        chk("post_rst_addr", maddr, 16'hB456);
        run("post_rst", 1'b1, 2, 8'h77, 8'h00);
        // H-flagged ADS with simultaneous cont: set wins
        ads(12'h001, 8'h80, 1'b1);
        @(negedge clk);
        chk("halt_set_wins", halt, 1);
        chk("halt_flags", mflags, 4'h8);
        @(posedge clk); #1; cont = 1'b1;
        @(posedge clk); #1; cont = 1'b0;
        @(negedge clk);
        chk("halt_cont", halt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scmp_bus_ctl.md
# scmp_bus_ctl

Bus-cycle controller downstream of the SC/MP core. It demultiplexes the core's address-strobe cycle into a 16-bit address plus cycle flags, and converts the core's RD_n/WR_n strobes into a single-outstanding req/ack memory transaction. It stalls the core via `cpu_hold` until memory answers or a timeout fires. It sits between the core's external pins and the system memory/peripheral fabric.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles `mem_req` stays high without `mem_ack` before the cycle aborts. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cpu_addr`  in  12  core address, A11..A0.
- `cpu_D_o`  in  8  core data out.
  - During ADS: {H,D,I,R,A15..A12}.
  - During write: write data.
- `cpu_ADS_n`  in  1  address strobe, active-low.
- `cpu_RD_n`  in  1  read strobe, active-low.
- `cpu_WR_n`  in  1  write strobe, active-low.
- `cpu_D_i`  out  8  registered read data to the core.
- `cpu_hold`  out  1  stall request to the core microcode.
- `mem_addr`  out  16  latched full address.
- `mem_flags`  out  4  latched {H,D,I,R}.
- `mem_wdata`  out  8  latched write data.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_req`  out  1  request; held high until `mem_ack`.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req` is high.
- `mem_rdata`  in  8  read data; valid in the cycle `mem_ack` is high.
- `bus_err`  out  1  one-cycle pulse on timeout abort.
- `halt_o`  out  1  level, set by an H-flagged ADS.
- `cont_i`  in  1  clears `halt_o`.

## Operation
FSM states: IDLE, ADDR, RD_REQ, WR_REQ, DONE.

- **IDLE**
  - If `cpu_ADS_n`=0: latch `mem_addr`={cpu_D_o[3:0],cpu_addr} and `mem_flags`=cpu_D_o[7:4], then go to ADDR.
  - Read/write strobes without a prior ADS are ignored.
- **ADDR**
  - `cpu_ADS_n`=0 again: relatch address and flags, stay in ADDR.
  - Else `cpu_RD_n`=0: go to RD_REQ with `mem_we`=0.
  - Else `cpu_WR_n`=0: latch `mem_wdata`=cpu_D_o, go to WR_REQ with `mem_we`=1.
  - RD and WR both low: read takes priority.
- **RD_REQ / WR_REQ**
  - `mem_req`=1 throughout. The wait counter clears on entry and increments each cycle without ack.
  - `mem_ack`=1: a read captures `cpu_D_i`=mem_rdata. Go to DONE.
  - Timeout (TIMEOUT≠0, counter==TIMEOUT-1, no ack): a read sets `cpu_D_i`=8'hFF, `bus_err` pulses, go to DONE. Ack in the same cycle as timeout: ack wins, no error.
- **DONE**
  - `mem_req`=0.
  - When `cpu_RD_n` and `cpu_WR_n` are both high, go to IDLE.
  - `cpu_D_i` holds its value until the next read completes.
- **`cpu_hold`** (combinational): (ADDR and (RD_n=0 or WR_n=0)) or RD_REQ or WR_REQ.
- **`halt_o`**:
  - Sets on the IDLE/ADDR address latch when cpu_D_o[7]=1.
  - Clears when `cont_i`=1.
  - Set wins over a simultaneous clear.
- **Counter width:** $clog2(TIMEOUT+1); minimum 1.

## Timing
- **Reset:** synchronous. Next edge with `rst_n`=0 forces:
  - state IDLE
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_flags`=0, `mem_wdata`=0
  - `cpu_D_i`=0, `cpu_hold`=0, `bus_err`=0, `halt_o`=0
- **Reset mid-transaction:** drops `mem_req` immediately at that edge. A late `mem_ack` seen in IDLE is ignored.
- **Address path:** ADS low at edge N puts `mem_addr`/`mem_flags` valid from cycle N+1.
- **Request timing:**
  - Strobe sampled at edge N (state ADDR): `cpu_hold` is high combinationally in cycle N.
  - `mem_req` is high from cycle N+1.
- **Completion timing:** ack sampled at edge M gives DONE from M+1, `mem_req`=0, `cpu_hold`=0, and read data valid on `cpu_D_i`.
- **Zero-wait memory** (ack in the first REQ cycle): hold spans 2 cycles.
- **Timeout:** `mem_req` is high exactly TIMEOUT cycles. `bus_err` is high for the single cycle after the last of them.
- **Single outstanding:** at most one transaction in flight. `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1.

## Test plan
- **Zero-wait read:** ADS with cpu_addr=12'h345 and cpu_D_o=8'hA7, then RD_n low, mem_ack same cycle as first req, mem_rdata=8'h5C.
  - Expect mem_addr=16'h7345, mem_flags=4'hA, mem_we=0, halt_o=1.
  - Expect cpu_D_i=8'h5C and cpu_hold=0 one cycle after ack.
- **Wait-state read:** ack delayed 3 cycles.
  - Expect mem_req high 4 cycles, cpu_hold high 5 cycles, no bus_err.
- **Write:** ADS with addr 12'h0FF and D_o=8'h10, then WR_n low with cpu_D_o=8'h3C.
  - Expect mem_addr=16'h00FF, mem_we=1, mem_wdata=8'h3C, mem_req dropped the cycle after ack, cpu_D_i unchanged.
- **Timeout, TIMEOUT=16, no ack:**
  - Expect mem_req high exactly 16 cycles, bus_err a 1-cycle pulse, cpu_D_i=8'hFF, hold released.
  - Repeat with ack on the 16th cycle: no error.
- **Reset mid-RD_REQ:** assert rst_n=0 for 1 cycle.
  - Expect all outputs 0 at the next edge.
  - A late mem_ack is ignored.
  - The following ADS/RD proceeds normally.
- **Halt/cont:**
  - H-flagged ADS with cont_i=1 in the same cycle: halt_o=1.
  - Later cont_i pulse: halt_o=0 the next cycle.
